// File: rtl/rover_drive_ctrl_if.sv
// Command and status bundle between the rover supervisor and the drive controller.
interface rover_drive_ctrl_if;
    logic       en;
    logic       dir_rev;
    logic       turn_r;
    logic       turn_l;
    logic [2:0] level;
    logic [1:0] oc;
    logic [1:0] ena;
    logic [3:0] hb_in;
    logic       fault;
    logic [7:0] fault_count;
    logic [1:0] state;

    modport master (
        output en, dir_rev, turn_r, turn_l, level, oc,
        input  ena, hb_in, fault, fault_count, state
    );

    modport slave (
        input  en, dir_rev, turn_r, turn_l, level, oc,
        output ena, hb_in, fault, fault_count, state
    );
endinterface

// File: rtl/rover_drive_ctrl.sv
// Dual H-bridge drive controller: ramped PWM speed, dead time on direction change,
// and an overcurrent lockout that must see a clean hold window before re-arming.
module rover_drive_ctrl #(
    parameter int CNT_W      = 10,
    parameter int PERIOD     = 1000,
    parameter int RAMP_STEP  = 25,
    parameter int DEAD_CYC   = 50,
    parameter int FAULT_HOLD = 100000
) (
    input  logic               clk,
    input  logic               rst,
    rover_drive_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Duty is one bit wider than the counter so a full-period duty (constant high) fits.
    localparam int DW     = CNT_W + 1;
    localparam int QTR    = PERIOD / 4;
    localparam int STEP_C = (RAMP_STEP > PERIOD) ? PERIOD : RAMP_STEP;
    localparam int DEADW  = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
    localparam int HW     = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD + 1) : 1;

    localparam logic [DW-1:0]    STEP_V   = DW'(STEP_C);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DEADW-1:0] DEAD_END = DEADW'(DEAD_CYC - 1);
    localparam logic [HW-1:0]    HOLD_END = HW'(FAULT_HOLD - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    duty_cur;
    logic [DW-1:0]    duty_ramp;
    logic [DW-1:0]    target;
    logic [2:0]       level_sat;
    logic [DEADW-1:0] dead_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [1:0]       oc_s1;
    logic [1:0]       oc_s2;
    logic [3:0]       hb_in;
    logic [3:0]       req_code;
    logic [7:0]       fault_cnt;
    logic [1:0]       ena;
    logic             wrap;
    logic             pwm;
    logic             oc_hit;
    logic             dead_done;
    logic             hold_done;

    assign wrap      = (cnt == CNT_LAST);
    assign pwm       = ({1'b0, cnt} < duty_cur);
    assign oc_hit    = |oc_s2;
    assign dead_done = (dead_cnt == DEAD_END);
    assign hold_done = (hold_cnt == HOLD_END);
    assign level_sat = (bus.level > 3'd4) ? 3'd4 : bus.level;
    assign target    = DW'(32'(level_sat) * QTR);

    // Right turn beats left turn, and any turn beats the straight-line direction.
    always_comb begin
        req_code = 4'b1001;
        if (bus.turn_r) begin
            req_code = 4'b0101;
        end else if (bus.turn_l) begin
            req_code = 4'b1010;
        end else if (bus.dir_rev) begin
            req_code = 4'b0110;
        end
    end

    always_comb begin
        duty_ramp = duty_cur;
        if (duty_cur < target) begin
            duty_ramp = ((target - duty_cur) > STEP_V) ? (duty_cur + STEP_V) : target;
        end else if (duty_cur > target) begin
            duty_ramp = ((duty_cur - target) > STEP_V) ? (duty_cur - STEP_V) : target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Overcurrent outranks en=0, which outranks a direction change.
    always_comb begin
        state_next = state;
        ena        = 2'b00;
        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_next = oc_hit ? FAULT : RUN;
                end
            end
            RUN: begin
                ena = {pwm, pwm};
                if (oc_hit) begin
                    state_next = FAULT;
                end else if (!bus.en) begin
                    state_next = IDLE;
                end else if (req_code != hb_in) begin
                    state_next = DEAD;
                end
            end
            DEAD: begin
                if (oc_hit) begin
                    state_next = FAULT;
                end else if (!bus.en) begin
                    state_next = IDLE;
                end else if (dead_done) begin
                    state_next = RUN;
                end
            end
            FAULT: begin
                if (!oc_hit && hold_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // PWM and ramp only advance while staying in RUN; any other path restarts them from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            duty_cur  <= '0;
            dead_cnt  <= '0;
            hold_cnt  <= '0;
            oc_s1     <= 2'b00;
            oc_s2     <= 2'b00;
            hb_in     <= 4'b0000;
            fault_cnt <= 8'd0;
        end else begin
            oc_s1 <= bus.oc;
            oc_s2 <= oc_s1;

            if (state == RUN && state_next == RUN) begin
                cnt <= wrap ? '0 : cnt + 1'b1;
                if (wrap) begin
                    duty_cur <= duty_ramp;
                end
            end else begin
                cnt      <= '0;
                duty_cur <= '0;
            end

            dead_cnt <= (state == DEAD && state_next == DEAD) ? dead_cnt + 1'b1 : '0;
            hold_cnt <= (state == FAULT && state_next == FAULT && !oc_hit) ? hold_cnt + 1'b1 : '0;

            if ((state == IDLE || state == DEAD) && state_next == RUN) begin
                hb_in <= req_code;
            end

            if (state != FAULT && state_next == FAULT && fault_cnt != 8'hFF) begin
                fault_cnt <= fault_cnt + 8'd1;
            end
        end
    end

    assign bus.ena         = ena;
    assign bus.hb_in       = hb_in;
    assign bus.state       = state;
    assign bus.fault       = (state == FAULT);
    assign bus.fault_count = fault_cnt;

endmodule

// File: doc/rover_drive_ctrl.md
ROVER_DRIVE_CTRL -- requirements
Module: rover_drive_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 10, PWM counter and duty width in bits.
REQ-002 SHALL have parameter PERIOD, default 1000, PWM period in clk cycles; 4 <= PERIOD <= 2**CNT_W, PERIOD divisible by 4.
REQ-003 SHALL have parameter RAMP_STEP, default 25, maximum duty change per PWM period.
REQ-004 SHALL have parameter DEAD_CYC, default 50, dead-time cycles inserted on direction change.
REQ-005 SHALL have parameter FAULT_HOLD, default 100000, overcurrent-free cycles required to leave FAULT.
REQ-006 Ports: clk in 1 system clock; rst in 1 synchronous active-high reset.
REQ-007 Ports: en in 1 rover on/off; dir_rev in 1 reverse request; turn_r in 1 right-turn request; turn_l in 1 left-turn request.
REQ-008 Ports: level in 3 requested speed in quarters (0..4); oc in 2 asynchronous overcurrent flags {B,A}.
REQ-009 Ports: ena out 2 H-bridge enables {B,A}; hb_in out 4 H-bridge inputs {IN4,IN3,IN2,IN1}.
REQ-010 Ports: fault out 1 FAULT-state flag; fault_count out 8 fault-entry count; state out 2 current state.

Function
REQ-011 The clock SHALL be clk only; rst SHALL be synchronous and active-high, sampled on the rising edge of clk.
REQ-012 Requested code SHALL be: turn_r -> 0101; else turn_l -> 1010; else dir_rev -> 0110; else 1001 (turn_r wins when both turns are set).
REQ-013 Target duty SHALL be min(level,4)*PERIOD/4, so level values 5..7 saturate to 100%.
REQ-014 PWM counter SHALL count 0..PERIOD-1, wrap to 0, and be held at 0 outside RUN.
REQ-015 pwm SHALL be (cnt < duty_cur); duty_cur = PERIOD SHALL give a constant-high output.
REQ-016 duty_cur SHALL update only on the wrap edge (cnt = PERIOD-1), moving toward target by at most RAMP_STEP in either direction and landing exactly on target without overshoot.
REQ-017 States SHALL be IDLE=0, RUN=1, DEAD=2, FAULT=3.
REQ-018 In IDLE, ena SHALL be 00 and duty_cur 0; en=1 SHALL move to RUN next edge and load hb_in with the requested code on that edge, with no dead time.
REQ-019 In RUN, ena SHALL be {pwm,pwm}; en=0 SHALL move to IDLE next edge.
REQ-020 In RUN, a requested code differing from hb_in SHALL move to DEAD; hb_in SHALL be held.
REQ-021 In DEAD, ena SHALL be 00 for exactly DEAD_CYC cycles, after which hb_in SHALL load the current requested code, duty_cur and cnt SHALL clear, and the state SHALL return to RUN.
REQ-022 en=0 in DEAD SHALL move to IDLE.
REQ-023 oc SHALL pass through a 2-flop synchroniser; synchronised oc != 00 in RUN, DEAD or IDLE-with-en=1 SHALL move to FAULT.
REQ-024 If oc is first sampled high at edge N, state SHALL be FAULT and ena 00 from edge N+2.
REQ-025 In FAULT, ena SHALL be 00, fault 1, and hb_in SHALL be held.
REQ-026 In FAULT, the hold counter SHALL restart on any synchronised oc high and SHALL move to IDLE after FAULT_HOLD consecutive clean cycles, regardless of en.
REQ-027 fault_count SHALL increment on each FAULT entry and saturate at 255.
REQ-028 Transition priority SHALL be rst > overcurrent > en=0 > direction change.
REQ-029 A level change SHALL never cause DEAD; it SHALL only retarget the ramp.

Reset
REQ-030 rst SHALL force state IDLE, ena 00, hb_in 0000, cnt 0, duty_cur 0, hold and dead counters 0, synchroniser 00, fault 0, fault_count 0, from any state including mid-DEAD and mid-FAULT.

Verification (PERIOD=8, RAMP_STEP=2, DEAD_CYC=3, FAULT_HOLD=10)
REQ-031 rst, then en=1, level=4, dir_rev=0 -> state=1 and hb_in=1001 after one edge; high-time per period 0,2,4,6,8; then ena=11 constant.
REQ-032 Steady RUN at level=2 -> ena=11 for cnt 0..3 and 00 for cnt 4..7 every period; level 2->7 ramps 4,6,8.
REQ-033 In RUN, dir_rev 0->1 -> state=2, ena=00 for exactly 3 cycles, then hb_in=0110, state=1, ramp restarts from 0.
REQ-034 turn_r=turn_l=1 -> hb_in=0101; in RUN, clearing turn_r -> DEAD, then 1010.
REQ-035 One-cycle oc=01 at edge N -> ena=00 and fault=1 from N+2, fault_count=1; 10 clean cycles -> IDLE, then RUN if en=1; second oc pulse mid-hold restarts the count.
REQ-036 rst mid-FAULT with fault_count=3 -> all REQ-030 values on the next edge; en=1 then enters RUN normally.
